cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_unit_pkg.sv | 70 +++++++
 rtl/cp0_timer.sv | 60 ++++++
 rtl/cp0_unit.sv | 154 +++++++++++++++
 tb/tb_cp0_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_unit_pkg
//  Description : Shared CP0 definitions: register number/select constants,
//                write masks, Status/Cause field layouts, exception codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_unit_pkg;

    // Register numbers and selects decoded by MFC0/MTC0
    localparam logic [4:0] c_REG_BADVADDR = 5'd8;
    localparam logic [4:0] c_REG_COUNT    = 5'd9;
    localparam logic [4:0] c_REG_COMPARE  = 5'd11;
    localparam logic [4:0] c_REG_STATUS   = 5'd12;
    localparam logic [4:0] c_REG_CAUSE    = 5'd13;
    localparam logic [4:0] c_REG_EPC      = 5'd14;
    localparam logic [4:0] c_REG_PRID     = 5'd15;
    localparam logic [4:0] c_REG_CONFIG   = 5'd16;
    localparam logic [4:0] c_REG_ERROREPC = 5'd30;
    localparam logic [2:0] c_SEL0         = 3'd0;
    localparam logic [2:0] c_SEL1         = 3'd1;

    // Software-writable bits; everything else is read-only or hardware-owned
    localparam logic [31:0] c_STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] c_CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] c_STATUS_RESET = 32'h0040_0000;
    // Config0: M bit set to advertise Config1
    localparam logic [31:0] c_CONFIG0_VALUE = 32'h8000_0000;

    typedef struct packed {
        logic [8:0] rsvd_hi;
        logic       bev;
        logic [5:0] rsvd_mid;
        logic [7:0] im;
        logic [5:0] rsvd_lo;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] rsvd_hi;
        logic [7:0]  ip;
        logic        rsvd_mid;
        logic [4:0]  exc_code;
        logic [1:0]  rsvd_lo;
    } cause_t;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_timer
//  Description : Count/Compare timer. Count advances every second cycle,
//                a Count==Compare match sets a sticky TI flag, a Compare
//                write clears it.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic [31:0] w_count_next;

    // Next Count: a software load wins over the half-rate increment
    always_comb begin
        w_count_next = r_count;
        if (count_we) begin
            w_count_next = wr_data;
        end else if (r_tick) begin
            w_count_next = r_count + 32'd1;
        end
    end

    // Timer state; Compare write clear beats a same-cycle match
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick    <= 1'b0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_tick  <= ~r_tick;
            r_count <= w_count_next;
            if (compare_we) begin
                r_compare <= wr_data;
                r_ti      <= 1'b0;
            end else if (w_count_next == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign count   = r_count;
    assign compare = r_compare;
    assign ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_unit
//  Description : MIPS-style coprocessor 0: MFC0/MTC0 access, exception entry,
//                ERET, interrupt pending generation.
//  Config      : define CP0_TIMER_INTR_EN to enable the Count/Compare timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE    = 32'h0001_8003,
    parameter logic [31:0] CONFIG1_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_reg,
    input  logic [2:0]  rd_sel,
    output logic [31:0] rd_data,
    output logic        rd_invalid,
    input  logic        wr_en,
    input  logic [4:0]  wr_reg,
    input  logic [2:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_badvaddr,
    input  logic        exc_bad_valid,
    input  logic        eret,
    input  logic [5:0]  ext_int,
    output logic [31:0] epc_out,
    output logic [31:0] status_out,
    output logic        int_pending
);

    status_t     r_status;
    logic        r_bd;
    logic [4:0]  r_exc_code;
    logic [1:0]  r_ip_sw;
    logic [5:0]  r_ip_hw;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_errorepc;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic        w_wr_ok;
    cause_t      w_cause;

    // An MTC0 only lands when no exception or ERET claims the cycle
    assign w_wr_ok = wr_en & ~exc_valid & ~eret;

`ifdef CP0_TIMER_INTR_EN
    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (w_wr_ok && wr_reg == c_REG_COUNT && wr_sel == c_SEL0),
        .compare_we (w_wr_ok && wr_reg == c_REG_COMPARE && wr_sel == c_SEL0),
        .wr_data    (wr_data),
        .count      (w_count),
        .compare    (w_compare),
        .ti         (w_ti)
    );
`else
    logic [31:0] r_compare;

    // Without the timer Compare is just a scratch register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_compare <= '0;
        end else if (w_wr_ok && wr_reg == c_REG_COMPARE && wr_sel == c_SEL0) begin
            r_compare <= wr_data;
        end
    end

    assign w_compare = r_compare;
    assign w_count   = '0;
    assign w_ti      = 1'b0;
`endif

    // Assemble Cause from its separately owned fields
    always_comb begin
        w_cause          = '0;
        w_cause.bd       = r_bd;
        w_cause.ti       = w_ti;
        w_cause.ip       = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
        w_cause.exc_code = r_exc_code;
    end

    // Architectural state: exception entry > ERET > MTC0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status   <= c_STATUS_RESET;
            r_bd       <= 1'b0;
            r_exc_code <= '0;
            r_ip_sw    <= '0;
            r_ip_hw    <= '0;
            r_epc      <= '0;
            r_badvaddr <= '0;
            r_errorepc <= '0;
        end else begin
            r_ip_hw <= ext_int;
            if (exc_valid) begin
                r_status.exl <= 1'b1;
                r_exc_code   <= exc_code;
                // Nested exceptions keep the original return point
                if (!r_status.exl) begin
                    r_epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
                    r_bd  <= exc_bd;
                end
                if (exc_bad_valid) begin
                    r_badvaddr <= exc_badvaddr;
                end
            end else if (eret) begin
                r_status.exl <= 1'b0;
            end else if (wr_en && wr_sel == c_SEL0) begin
                case (wr_reg)
                    c_REG_STATUS:   r_status   <= apply_mask(r_status, wr_data, c_STATUS_WMASK);
                    c_REG_CAUSE:    r_ip_sw    <= wr_data[9:8];
                    c_REG_EPC:      r_epc      <= wr_data;
                    c_REG_ERROREPC: r_errorepc <= wr_data;
                    default:        ;
                endcase
            end
        end
    end

    // MFC0 read mux, purely from current state
    always_comb begin
        rd_data    = '0;
        rd_invalid = 1'b0;
        case ({rd_reg, rd_sel})
            {c_REG_BADVADDR, c_SEL0}: rd_data = r_badvaddr;
            {c_REG_COUNT,    c_SEL0}: rd_data = w_count;
            {c_REG_COMPARE,  c_SEL0}: rd_data = w_compare;
            {c_REG_STATUS,   c_SEL0}: rd_data = r_status;
            {c_REG_CAUSE,    c_SEL0}: rd_data = w_cause;
            {c_REG_EPC,      c_SEL0}: rd_data = r_epc;
            {c_REG_PRID,     c_SEL0}: rd_data = PRID_VALUE;
            {c_REG_CONFIG,   c_SEL0}: rd_data = c_CONFIG0_VALUE;
            {c_REG_CONFIG,   c_SEL1}: rd_data = CONFIG1_VALUE;
            {c_REG_ERROREPC, c_SEL0}: rd_data = r_errorepc;
            default:                  rd_invalid = 1'b1;
        endcase
    end

    assign epc_out     = r_epc;
    assign status_out  = r_status;
    assign int_pending = ~reset & r_status.ie & ~r_status.exl & |(w_cause.ip & r_status.im);

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_unit
//  Description : Directed self-checking bench for cp0_unit.
//  Config      : timer checks follow CP0_TIMER_INTR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;

    localparam logic [31:0] c_PRID = 32'h0001_8003;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_reg;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        rd_invalid;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        exc_bad_valid;
    logic        eret;
    logic [5:0]  ext_int;
    logic [31:0] epc_out;
    logic [31:0] status_out;
    logic        int_pending;

    int n_checks = 0;
    int n_errors = 0;

    cp0_unit #(.PRID_VALUE(c_PRID), .CONFIG1_VALUE(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_reg        (rd_reg),
        .rd_sel        (rd_sel),
        .rd_data       (rd_data),
        .rd_invalid    (rd_invalid),
        .wr_en         (wr_en),
        .wr_reg        (wr_reg),
        .wr_sel        (wr_sel),
        .wr_data       (wr_data),
        .exc_valid     (exc_valid),
        .exc_code      (exc_code),
        .exc_pc        (exc_pc),
        .exc_bd        (exc_bd),
        .exc_badvaddr  (exc_badvaddr),
        .exc_bad_valid (exc_bad_valid),
        .eret          (eret),
        .ext_int       (ext_int),
        .epc_out       (epc_out),
        .status_out    (status_out),
        .int_pending   (int_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] r, input logic [2:0] s, output logic [31:0] d);
        rd_reg = r;
        rd_sel = s;
        #1;
        d = rd_data;
    endtask

    task automatic wr(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_reg  = r;
        wr_sel  = s;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic exc(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                       input logic bad, input logic [31:0] bva);
        exc_valid     = 1'b1;
        exc_pc        = pc;
        exc_bd        = bd;
        exc_code      = code;
        exc_bad_valid = bad;
        exc_badvaddr  = bva;
        step();
        exc_valid = 1'b0;
    endtask

    logic [31:0] v;
    int          n_wait;

    initial begin
        reset = 1'b1; rd_reg = '0; rd_sel = '0;
        wr_en = 1'b0; wr_reg = '0; wr_sel = '0; wr_data = '0;
        exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
        exc_badvaddr = '0; exc_bad_valid = 1'b0; eret = 1'b0; ext_int = '0;
        step(); step();
        chk("int_pending_in_reset", {31'b0, int_pending}, 32'd0);
        reset = 1'b0;

        // Reset values and decode
        rd(5'd12, 3'd0, v); chk("status_reset", v, 32'h0040_0000);
        rd(5'd15, 3'd0, v); chk("prid", v, c_PRID);
        rd(5'd5, 3'd0, v);  chk("invalid_data", v, 32'd0);
        chk("invalid_flag", {31'b0, rd_invalid}, 32'd1);
        step();

        // Compare is writable in both builds; this also clears any reset-time TI
        wr(5'd11, 3'd0, 32'h8000_0000);
        rd(5'd11, 3'd0, v); chk("compare_rw", v, 32'h8000_0000);

        // Write masks, and no bypass on a same-cycle read
        wr_en = 1'b1; wr_reg = 5'd12; wr_sel = 3'd0; wr_data = 32'hFFFF_FFFF;
        rd(5'd12, 3'd0, v); chk("status_no_bypass", v, 32'h0040_0000);
        step(); wr_en = 1'b0;
        rd(5'd12, 3'd0, v); chk("status_mask", v, 32'h0040_FF03);
        wr(5'd13, 3'd0, 32'hFFFF_FFFF);
        rd(5'd13, 3'd0, v); chk("cause_mask", v, 32'h0000_0300);
        wr(5'd13, 3'd0, 32'h0);
        wr(5'd12, 3'd0, 32'h0000_8001);
        chk("status_out", status_out, 32'h0040_8001);

`ifdef CP0_TIMER_INTR_EN
        // Timer match latency and interrupt
        wr(5'd11, 3'd0, 32'd5);
        wr(5'd9, 3'd0, 32'd0);
        n_wait = 1;
        rd(5'd13, 3'd0, v);
        while (v[30] == 1'b0 && n_wait < 20) begin
            step();
            n_wait++;
            rd(5'd13, 3'd0, v);
        end
        chk("ti_set", {31'b0, v[30]}, 32'd1);
        chk("ti_window", {31'b0, (n_wait == 10 || n_wait == 11)}, 32'd1);
        chk("timer_int_pending", {31'b0, int_pending}, 32'd1);
        wr(5'd11, 3'd0, 32'h8000_0000);
        rd(5'd13, 3'd0, v);
        chk("ti_cleared", {31'b0, v[30]}, 32'd0);
        chk("timer_int_cleared", {31'b0, int_pending}, 32'd0);
`else
        // Timer absent: Count frozen at zero, TI never set
        wr(5'd9, 3'd0, 32'h0000_1234);
        step(); step();
        rd(5'd9, 3'd0, v);  chk("count_frozen", v, 32'd0);
        rd(5'd13, 3'd0, v); chk("ti_zero", {31'b0, v[30]}, 32'd0);
`endif

        // First exception: branch-delay slot
        exc(32'hBFC0_0100, 1'b1, 5'd4, 1'b1, 32'h0000_0123);
        chk("epc_bd", epc_out, 32'hBFC0_00FC);
        rd(5'd14, 3'd0, v); chk("epc_read", v, 32'hBFC0_00FC);
        rd(5'd13, 3'd0, v);
        chk("cause_bd", {31'b0, v[31]}, 32'd1);
        chk("cause_exccode", {27'b0, v[6:2]}, 32'd4);
        chk("status_exl_set", status_out, 32'h0040_8003);
        rd(5'd8, 3'd0, v); chk("badvaddr", v, 32'h0000_0123);

        // Nested exception keeps EPC/BD, updates ExcCode
        exc(32'h0000_0200, 1'b0, 5'd5, 1'b0, 32'h0000_0999);
        chk("epc_nested", epc_out, 32'hBFC0_00FC);
        rd(5'd13, 3'd0, v);
        chk("bd_nested", {31'b0, v[31]}, 32'd1);
        chk("exccode_nested", {27'b0, v[6:2]}, 32'd5);
        rd(5'd8, 3'd0, v); chk("badvaddr_kept", v, 32'h0000_0123);

        eret = 1'b1; step(); eret = 1'b0;
        chk("eret_exl", status_out, 32'h0040_8001);

        // Exception + ERET + Status write in one cycle
        exc_valid = 1'b1; exc_pc = 32'h0000_0300; exc_bd = 1'b0; exc_code = 5'd8;
        exc_bad_valid = 1'b0; eret = 1'b1;
        wr_en = 1'b1; wr_reg = 5'd12; wr_sel = 3'd0; wr_data = 32'hFFFF_FFFF;
        step();
        exc_valid = 1'b0; eret = 1'b0; wr_en = 1'b0;
        chk("prio_status", status_out, 32'h0040_8003);
        chk("prio_epc", epc_out, 32'h0000_0300);
        rd(5'd13, 3'd0, v);
        chk("prio_exccode", {27'b0, v[6:2]}, 32'd8);
        chk("prio_bd", {31'b0, v[31]}, 32'd0);
        eret = 1'b1; step(); eret = 1'b0;
        chk("lone_eret", status_out, 32'h0040_8001);

        // External interrupt on IP2
        wr(5'd12, 3'd0, 32'h0000_0401);
        ext_int = 6'b000001;
        #1;
        chk("ext_int_not_yet", {31'b0, int_pending}, 32'd0);
        step();
        chk("ext_int_pending", {31'b0, int_pending}, 32'd1);
        wr(5'd12, 3'd0, 32'h0000_0403);
        chk("ext_int_masked_exl", {31'b0, int_pending}, 32'd0);
        wr(5'd12, 3'd0, 32'h0000_0401);
        chk("ext_int_again", {31'b0, int_pending}, 32'd1);

        // Reset overrides a concurrent exception
        reset = 1'b1;
        exc_valid = 1'b1; exc_pc = 32'h0000_0400; exc_bd = 1'b0; exc_code = 5'd10;
        #1;
        chk("reset_int_pending", {31'b0, int_pending}, 32'd0);
        step();
        exc_valid = 1'b0; reset = 1'b0; ext_int = '0;
        chk("reset_status", status_out, 32'h0040_0000);
        chk("reset_epc", epc_out, 32'd0);
        rd(5'd8, 3'd0, v); chk("reset_badvaddr", v, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
